// File: rtl/seg_serial_rx.sv
// Receiver for the serial 7-segment display link: synchronizes SEGCLK/SEGCLR/SEGDT/SEGEN,
// deserializes frames and flags short frames and overruns. Optional decode: `define SEG_DECODE_EN.
module seg_serial_rx #(
  parameter int DATA_W      = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SEGCLK,
  input  logic              SEGCLR,
  input  logic              SEGDT,
  input  logic              SEGEN,
  output logic [DATA_W-1:0] frame,
  output logic              frame_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic [6:0]        bit_cnt
`ifdef SEG_DECODE_EN
  ,
  output logic [4*DATA_W/8-1:0] digits,
  output logic [DATA_W/8-1:0]   digit_ok
`endif
);

  localparam logic [6:0] CNT_FULL = 7'(DATA_W);
  localparam logic [6:0] CNT_MAX  = 7'(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, clr_sync_q, dt_sync_q, en_sync_q;
  logic                   clk_prev_q, en_prev_q;
  logic                   shift_ev, latch_ev, clear_act, dt_s;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   frame_q, frame_d;
  logic [6:0]          cnt_q, cnt_d;
  logic                ovr_q, ovr_d;
  logic                fv_q, fv_d;
  logic                fe_q, fe_d;

  // Every serial input sees the same number of sync stages, so SEGDT stays aligned to SEGCLK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '0;
      clr_sync_q <= '0;
      dt_sync_q  <= '0;
      en_sync_q  <= '0;
      clk_prev_q <= 1'b0;
      en_prev_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let each flop sample the previous value of its neighbour.
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], SEGCLK};
      clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], SEGCLR};
      dt_sync_q  <= {dt_sync_q[SYNC_STAGES-2:0], SEGDT};
      en_sync_q  <= {en_sync_q[SYNC_STAGES-2:0], SEGEN};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
      en_prev_q  <= en_sync_q[SYNC_STAGES-1];
    end
  end

  assign shift_ev  = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
  assign latch_ev  = en_sync_q[SYNC_STAGES-1] & ~en_prev_q;
  assign clear_act = ~clr_sync_q[SYNC_STAGES-1];
  assign dt_s      = dt_sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    shreg_d = shreg_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    if (clear_act) begin
      shreg_d = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
      state_d = IDLE;
    end else begin
      if (shift_ev) begin
        shreg_d = {shreg_q[DATA_W-2:0], dt_s};
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 7'd1;
        if (state_q == FULL) ovr_d = 1'b1;
        state_d = (cnt_d >= CNT_FULL) ? FULL : SHIFT;
      end
      // Latch is judged on the post-shift state so a coincident final bit is included.
      if (latch_ev) begin
        case (state_d)
          FULL: begin
            frame_d = shreg_d;
            fv_d    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
          SHIFT: begin
            fe_d    = 1'b1;
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      frame_q <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign overrun     = ovr_q;
  assign bit_cnt     = cnt_q;

`ifdef SEG_DECODE_EN
  localparam int NDIG = DATA_W / 8;

  // Segments are active-low, bit order dp,g,f,e,d,c,b,a; dp is masked off. Returns {ok, nibble}.
  function automatic logic [4:0] seg_to_hex(input logic [6:0] s);
    case (s)
      7'h40: seg_to_hex = 5'h10;  7'h79: seg_to_hex = 5'h11;
      7'h24: seg_to_hex = 5'h12;  7'h30: seg_to_hex = 5'h13;
      7'h19: seg_to_hex = 5'h14;  7'h12: seg_to_hex = 5'h15;
      7'h02: seg_to_hex = 5'h16;  7'h78: seg_to_hex = 5'h17;
      7'h00: seg_to_hex = 5'h18;  7'h10: seg_to_hex = 5'h19;
      7'h08: seg_to_hex = 5'h1A;  7'h03: seg_to_hex = 5'h1B;
      7'h46: seg_to_hex = 5'h1C;  7'h21: seg_to_hex = 5'h1D;
      7'h06: seg_to_hex = 5'h1E;  7'h0E: seg_to_hex = 5'h1F;
      default: seg_to_hex = 5'h00;
    endcase
  endfunction

  logic [4*NDIG-1:0] digits_d, digits_q;
  logic [NDIG-1:0]   ok_d, ok_q;

  always_comb begin
    digits_d = '0;
    ok_d     = '0;
    for (int i = 0; i < NDIG; i++) begin
      logic [4:0] dec;
      dec              = seg_to_hex(frame_d[8*i +: 7]);
      digits_d[4*i +: 4] = dec[3:0];
      ok_d[i]            = dec[4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      ok_q     <= '0;
    end else if (fv_d) begin
      digits_q <= digits_d;
      ok_q     <= ok_d;
    end
  end

  assign digits   = digits_q;
  assign digit_ok = ok_q;
`endif

endmodule

// File: tb/tb_seg_serial_rx.sv
// Self-checking bench for seg_serial_rx: random serial frames compared against a bit-queue
// model of the link (frame = last DATA_W bits received since the previous clear/latch).
module tb_seg_serial_rx;
  localparam int DATA_W = 64;
  localparam int SS     = 2;
  localparam int HOLD   = SS + 2;

  logic              clk = 1'b0;
  logic              rst_n, SEGCLK, SEGCLR, SEGDT, SEGEN;
  logic [DATA_W-1:0] frame;
  logic              frame_valid, frame_err, overrun;
  logic [6:0]        bit_cnt;

  seg_serial_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .SEGCLK(SEGCLK), .SEGCLR(SEGCLR), .SEGDT(SEGDT), .SEGEN(SEGEN),
    .frame(frame), .frame_valid(frame_valid), .frame_err(frame_err),
    .overrun(overrun), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0;
  int fv_seen = 0, fe_seen = 0, both_seen = 0;

  // Reference model state
  bit                mq[$];
  int                m_cnt = 0;
  bit                m_ovr = 1'b0;
  logic [DATA_W-1:0] m_frame = '0;
  int                exp_fv = 0, exp_fe = 0;

  always @(negedge clk) if (rst_n) begin
    if (frame_valid) fv_seen++;
    if (frame_err) fe_seen++;
    if (frame_valid && frame_err) both_seen++;
  end

  function void m_shift(bit b);
    mq.push_back(b);
    if (mq.size() > DATA_W) begin
      m_ovr = 1'b1;
      void'(mq.pop_front());
    end
    if (m_cnt < DATA_W + 1) m_cnt++;
  endfunction

  function void m_latch();
    if (m_cnt >= DATA_W) begin
      m_frame = '0;
      foreach (mq[i]) m_frame = (m_frame << 1) | DATA_W'(mq[i]);
      exp_fv++;
    end else if (m_cnt > 0) begin
      exp_fe++;
    end
    m_cnt = 0;
    mq.delete();
  endfunction

  function void m_clear();
    mq.delete();
    m_cnt = 0;
    m_ovr = 1'b0;
  endfunction

  task automatic wait_clk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(bit b);
    SEGDT = b;
    wait_clk(HOLD);
    SEGCLK = 1'b1;
    wait_clk(HOLD);
    SEGCLK = 1'b0;
    m_shift(b);
  endtask

  task automatic send_random(int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic do_latch();
    SEGEN = 1'b1;
    wait_clk(HOLD);
    SEGEN = 1'b0;
    wait_clk(HOLD);
    m_latch();
  endtask

  task automatic do_clear();
    SEGCLR = 1'b0;
    wait_clk(HOLD);
    SEGCLR = 1'b1;
    wait_clk(HOLD);
    m_clear();
  endtask

  task automatic cmp_state(string tag);
    n_total++;
    if ({frame, bit_cnt, overrun} !== {m_frame, 7'(m_cnt), m_ovr})
      $display("FAIL %s state: frame=%h bit_cnt=%0d overrun=%b, expected frame=%h bit_cnt=%0d overrun=%b",
               tag, frame, bit_cnt, overrun, m_frame, m_cnt, m_ovr);
    else n_pass++;
    n_total++;
    if (fv_seen !== exp_fv || fe_seen !== exp_fe)
      $display("FAIL %s pulses: frame_valid cycles=%0d frame_err cycles=%0d, expected %0d/%0d",
               tag, fv_seen, fe_seen, exp_fv, exp_fe);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; SEGCLK = 1'b0; SEGCLR = 1'b1; SEGDT = 1'b0; SEGEN = 1'b0;
    wait_clk(3);
    n_total++;
    if ({frame, bit_cnt, overrun, frame_valid, frame_err} !== '0)
      $display("FAIL reset: frame=%h bit_cnt=%0d overrun=%b fv=%b fe=%b, expected all 0",
               frame, bit_cnt, overrun, frame_valid, frame_err);
    else n_pass++;
    rst_n = 1'b1;
    wait_clk(HOLD);
  endtask

  task automatic test_full_frame();
    logic [DATA_W-1:0] pat;
    pat = 64'hC0F9A4B0_99929282;
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(pat[i]);
    cmp_state("full_pre_latch");
    do_latch();
    n_total++;
    if (frame !== pat) $display("FAIL full_pattern: frame=%h expected %h", frame, pat);
    else n_pass++;
    cmp_state("full_latch");
    for (int k = 0; k < 2; k++) begin
      send_random(DATA_W);
      do_latch();
      cmp_state("full_random");
    end
  endtask

  task automatic test_short_frame();
    send_random(40);
    cmp_state("short_pre_latch");
    do_latch();
    cmp_state("short_40");
    send_random(DATA_W - 1);
    do_latch();
    cmp_state("short_63");
  endtask

  task automatic test_simultaneous();
    bit b;
    send_random(DATA_W - 1);
    b = 1'($urandom_range(0, 1));
    SEGDT = b;
    wait_clk(HOLD);
    SEGCLK = 1'b1;
    SEGEN  = 1'b1;
    wait_clk(HOLD);
    SEGCLK = 1'b0;
    SEGEN  = 1'b0;
    wait_clk(HOLD);
    m_shift(b);
    m_latch();
    cmp_state("shift_and_latch");
  endtask

  task automatic test_overrun();
    send_random(70);
    cmp_state("overrun_pre_latch");
    do_latch();
    cmp_state("overrun_latch");
    send_random(DATA_W);
    do_latch();
    cmp_state("overrun_sticky");
    do_clear();
    cmp_state("overrun_cleared");
  endtask

  task automatic test_clear();
    send_random(30);
    do_clear();
    cmp_state("clear_mid");
    send_random(DATA_W);
    do_latch();
    cmp_state("clear_then_frame");
  endtask

  task automatic test_midframe_reset();
    send_random(20);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({frame, bit_cnt, overrun, frame_valid, frame_err} !== '0)
      $display("FAIL midframe_reset: frame=%h bit_cnt=%0d overrun=%b fv=%b fe=%b, expected all 0",
               frame, bit_cnt, overrun, frame_valid, frame_err);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    m_frame = '0;
    wait_clk(HOLD);
    send_random(DATA_W);
    do_latch();
    cmp_state("after_reset_frame");
  endtask

  task automatic test_idle_latch();
    do_latch();
    cmp_state("idle_latch");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_simultaneous();
    test_overrun();
    test_clear();
    test_midframe_reset();
    test_idle_latch();
    n_total++;
    if (both_seen !== 0) $display("FAIL exclusive_pulses: both high %0d cycles, expected 0", both_seen);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
